// File: rtl/note_sequencer.sv
// Tempo-driven note sequencer: steps a 64-word note RAM one word per beat and hands
// each note downstream over valid/ready. Define LOOP_EN to restart the song instead of stopping.
module note_sequencer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] END_CODE = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] note_data,
  output logic              note_valid,
  input  logic              note_ready,
  output logic [15:0]       beat_count,
  output logic              playing,
  output logic              done,
  output logic              overrun
);

`ifdef LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_FETCH,
    S_LATCH,
    S_OUT,
    S_DONE
  } state_t;

  state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_addr   <= '0;
      note_data  <= '0;
      note_valid <= 1'b0;
      beat_count <= '0;
      playing    <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // start outranks a coincident tick; the tick is simply lost
          if (start) begin
            state      <= S_PLAY;
            mem_addr   <= '0;
            beat_count <= '0;
            overrun    <= 1'b0;
            playing    <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_PLAY: begin
          done <= 1'b0;
          if (enable && !pause) state <= S_FETCH;
        end
        S_FETCH: begin
          if (enable) overrun <= 1'b1;
          state <= S_LATCH;
        end
        S_LATCH: begin
          if (enable) overrun <= 1'b1;
          note_data <= mem_rdata;
          if (mem_rdata == END_CODE) begin
            done <= 1'b1;
            if (LOOP) begin
              mem_addr <= '0;
              state    <= S_PLAY;
            end else begin
              playing <= 1'b0;
              state   <= S_DONE;
            end
          end else begin
            note_valid <= 1'b1;
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (enable) overrun <= 1'b1;
          if (note_ready) begin
            note_valid <= 1'b0;
            if (beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
            if (mem_addr == LAST_ADDR) begin
              done <= 1'b1;
              if (LOOP) begin
                mem_addr <= '0;
                state    <= S_PLAY;
              end else begin
                playing <= 1'b0;
                state   <= S_DONE;
              end
            end else begin
              mem_addr <= mem_addr + 1'b1;
              state    <= S_PLAY;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against a song-position model kept here.
module tb_note_sequencer;
  localparam logic [31:0] END_CODE = 32'hFFFF_FFFF;

  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, start = 1'b0, pause = 1'b0;
  logic        note_ready = 1'b0;
  logic [5:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] note_data;
  logic        note_valid;
  logic [15:0] beat_count;
  logic        playing, done, overrun;

  logic [31:0] ram [64];
  logic [31:0] got [$];
  int          pass_cnt = 0, total_cnt = 0;
  bit          chk_on = 1'b0;
  int          done_hi = 0;

  note_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .pause(pause),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .note_data(note_data),
    .note_valid(note_valid), .note_ready(note_ready), .beat_count(beat_count),
    .playing(playing), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= ram[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: song position, a fetch countdown after an accepted tick, and a pending note.
  bit          m_active, m_valid, m_ovr, m_done;
  int          m_fetch, m_addr, m_count;
  logic [31:0] m_data;

  task automatic song_end();
    m_done = 1'b1;
`ifdef LOOP_EN
    m_addr = 0;
`else
    m_active = 1'b0;
`endif
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_valid = 0; m_ovr = 0; m_done = 0;
      m_fetch = 0; m_addr = 0; m_count = 0; m_data = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_addr = 0; m_count = 0; m_ovr = 0; m_done = 0;
      end
    end else begin
      m_done = 0;
      if (m_valid) begin
        if (enable) m_ovr = 1;
        if (note_ready) begin
          m_valid = 0;
          if (m_count < 65535) m_count++;
          if (m_addr == 63) song_end();
          else m_addr++;
        end
      end else if (m_fetch > 0) begin
        if (enable) m_ovr = 1;
        m_fetch--;
        if (m_fetch == 0) begin
          m_data = ram[m_addr];
          if (m_data == END_CODE) song_end();
          else m_valid = 1;
        end
      end else if (enable && !pause) begin
        m_fetch = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("mem_addr",   32'(mem_addr),   32'(m_addr));
      check("note_data",  note_data,       m_data);
      check("note_valid", 32'(note_valid), 32'(m_valid));
      check("beat_count", 32'(beat_count), 32'(m_count));
      check("playing",    32'(playing),    32'(m_active));
      check("done",       32'(done),       32'(m_done));
      check("overrun",    32'(overrun),    32'(m_ovr));
      if (note_valid && note_ready && !reset) got.push_back(note_data);
      if (done) done_hi++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic cycles(input int n);
    repeat (n) step();
  endtask
  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask
  task automatic pulse_tick();
    enable = 1'b1; step(); enable = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1; cycles(2); reset = 1'b0; got.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h100 + i;
    #1 reset = 1'b1;
    chk_on = 1'b1;
    cycles(2);
    reset = 1'b0;
    step();
    check("reset_playing", 32'(playing), 32'd0);
    check("reset_count", 32'(beat_count), 32'd0);

    // 1: three notes then end code
    ram[0] = 32'hA; ram[1] = 32'hB; ram[2] = 32'hC; ram[3] = END_CODE;
    do_reset();
    note_ready = 1'b1;
    pulse_start();
    repeat (4) begin pulse_tick(); cycles(6); end
    check("t1_notes", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("t1_a", got[0], 32'hA);
      check("t1_b", got[1], 32'hB);
      check("t1_c", got[2], 32'hC);
    end
    check("t1_count", 32'(beat_count), 32'd3);
    check("t1_done", 32'(done), 32'd1);
    check("t1_valid", 32'(note_valid), 32'd0);
    pulse_start();
    check("t1_restart_play", 32'(playing), 32'd1);
    check("t1_restart_count", 32'(beat_count), 32'd0);
    check("t1_restart_done", 32'(done), 32'd0);

    // 2: backpressure holds the note
    ram[0] = 32'h1234;
    do_reset();
    note_ready = 1'b0;
    pulse_start();
    pulse_tick();
    cycles(2);
    for (int i = 0; i < 10; i++) begin
      check("t2_valid", 32'(note_valid), 32'd1);
      check("t2_data", note_data, 32'h1234);
      check("t2_count", 32'(beat_count), 32'd0);
      step();
    end
    note_ready = 1'b1;
    step();
    check("t2_count_after", 32'(beat_count), 32'd1);

    // 3: latency and overrun
    ram[0] = 32'h55; ram[1] = 32'h66;
    do_reset();
    note_ready = 1'b0;
    pulse_start();
    enable = 1'b1;
    step(); enable = 1'b0;
    check("t3_k1", 32'(note_valid), 32'd0);
    step();
    check("t3_k2", 32'(note_valid), 32'd0);
    step();
    check("t3_k3", 32'(note_valid), 32'd1);
    check("t3_ovr_before", 32'(overrun), 32'd0);
    pulse_tick();
    check("t3_ovr", 32'(overrun), 32'd1);
    note_ready = 1'b1;
    step();
    cycles(5);
    check("t3_no_extra", 32'(note_valid), 32'd0);
    check("t3_count", 32'(beat_count), 32'd1);
    check("t3_notes", 32'(got.size()), 32'd1);
    check("t3_ovr_sticky", 32'(overrun), 32'd1);

    // 4: pause discards ticks
    ram[0] = 32'h11; ram[1] = 32'h22;
    do_reset();
    note_ready = 1'b1;
    pulse_start();
    check("t4_ovr_clear", 32'(overrun), 32'd0);
    pulse_tick(); cycles(5);
    pause = 1'b1;
    repeat (3) begin pulse_tick(); cycles(3); end
    check("t4_addr_held", 32'(mem_addr), 32'd1);
    check("t4_no_note", 32'(got.size()), 32'd1);
    pause = 1'b0;
    pulse_tick(); cycles(5);
    check("t4_notes", 32'(got.size()), 32'd2);
    if (got.size() == 2) check("t4_next", got[1], 32'h22);

    // 5: async reset while a note is pending
    ram[0] = 32'h77;
    do_reset();
    note_ready = 1'b0;
    pulse_start();
    pulse_tick();
    begin
      int budget = 10;
      while (!note_valid && budget > 0) begin step(); budget--; end
      check("t5_reached_out", 32'(note_valid), 32'd1);
    end
    #2 reset = 1'b1;
    #1;
    check("t5_valid", 32'(note_valid), 32'd0);
    check("t5_data", note_data, 32'd0);
    check("t5_playing", 32'(playing), 32'd0);
    check("t5_addr", 32'(mem_addr), 32'd0);
    step(); reset = 1'b0;
    note_ready = 1'b1;
    got.delete();
    pulse_start();
    pulse_tick(); cycles(5);
    check("t5_restart", 32'(got.size()), 32'd1);
    if (got.size() == 1) check("t5_restart_data", got[0], 32'h77);

    // 6: full song of 64 notes
    for (int i = 0; i < 64; i++) ram[i] = 32'h0BAD_0000 + ($urandom & 32'hFFFF);
    do_reset();
    note_ready = 1'b1;
    pulse_start();
    done_hi = 0;
    repeat (64) begin pulse_tick(); cycles(5); end
    check("t6_count", 32'(beat_count), 32'd64);
`ifdef LOOP_EN
    check("t6_done_pulse", 32'(done_hi), 32'd1);
    check("t6_playing", 32'(playing), 32'd1);
    check("t6_addr", 32'(mem_addr), 32'd0);
    pulse_tick(); cycles(5);
    check("t6_count65", 32'(beat_count), 32'd65);
    check("t6_65th", got[got.size()-1], ram[0]);
`else
    check("t6_done", 32'(done), 32'd1);
    check("t6_playing", 32'(playing), 32'd0);
    pulse_tick(); cycles(5);
    check("t6_stays", 32'(beat_count), 32'd64);
`endif

    // randomized sessions
    for (int s = 0; s < 8; s++) begin
      reset = 1'b1;
      for (int i = 0; i < 64; i++) ram[i] = ($urandom_range(0, 15) == 0) ? END_CODE : $urandom;
      step();
      reset = 1'b0;
      for (int c = 0; c < 400; c++) begin
        start      = ($urandom_range(0, 29) == 0);
        enable     = ($urandom_range(0, 4) == 0);
        pause      = ($urandom_range(0, 5) == 0);
        note_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 399) == 0) begin #2 reset = 1'b1; #1 reset = 1'b0; end
        step();
      end
      start = 1'b0; enable = 1'b0; pause = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
